// File: rtl/io_input_controller.sv
// io_input_controller
//
// Input stage of the I/O module. Brings the raw confirm push-button and the
// board switches into the clock domain. Debounces the button and produces a
// single-cycle confirm pulse on each accepted press. Also runs the handshake
// that holds an IN instruction until the user confirms a switch value.
//
// Ports
//   clock          system clock (the only clock)
//   reset          asynchronous, active-high reset
//   confirm_n      raw push-button, active-low, asynchronous
//   switch_raw     raw switches, asynchronous
//   in_req         high while an IN instruction waits for data
//   in_ack         one-cycle pulse: in_data is valid and the request is done
//   in_data        last captured switch value, zero-extended to 32 bits
//   waiting        high while a request is pending and no press has been seen
//   confirm_pulse  one-cycle pulse on every debounced press
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | no request pending; presses only produce confirm_pulse
// WAIT_PRESS   | request pending, waiting for a debounced press
// WAIT_RELEASE | value delivered; hold here until the button is released

module io_input_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SW_WIDTH        = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                confirm_n,
    input  logic [SW_WIDTH-1:0] switch_raw,
    input  logic                in_req,
    output logic                in_ack,
    output logic [31:0]         in_data,
    output logic                waiting,
    output logic                confirm_pulse
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                btn_s1, btn_s2;
    logic [SW_WIDTH-1:0] sw_s1, sw_s2;

    logic                deb_pressed;
    logic [CNT_W-1:0]    deb_cnt;
    logic                mismatch;
    logic                deb_flip;
    logic                press_evt;
    logic                capture;

    // Two-flop synchronizers. The button chain resets to released (1).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_s1 <= 1'b1;
            btn_s2 <= 1'b1;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= confirm_n;
            btn_s2 <= btn_s1;
            sw_s1  <= switch_raw;
            sw_s2  <= sw_s1;
        end
    end

    // The accepted level flips once the synchronized level has disagreed
    // with it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle
    // restarts the count.
    assign mismatch  = (~btn_s2) != deb_pressed;
    assign deb_flip  = mismatch && (deb_cnt == CNT_LAST);
    assign press_evt = deb_flip && !deb_pressed;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            deb_pressed   <= 1'b0;
            deb_cnt       <= '0;
            confirm_pulse <= 1'b0;
        end else begin
            confirm_pulse <= press_evt;
            if (deb_flip) begin
                deb_pressed <= ~deb_pressed;
                deb_cnt     <= '0;
            end else if (mismatch) begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A dropped request takes priority over a press arriving in that cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_req) begin
                    state_nxt = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                if (!in_req) begin
                    state_nxt = IDLE;
                end else if (press_evt) begin
                    state_nxt = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (!deb_pressed) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        waiting = 1'b0;
        capture = 1'b0;
        case (state)
            WAIT_PRESS: begin
                waiting = 1'b1;
                capture = in_req && press_evt;
            end
            default: begin
                waiting = 1'b0;
                capture = 1'b0;
            end
        endcase
    end

    // Capture and ack land on the same edge as confirm_pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_ack  <= 1'b0;
            in_data <= '0;
        end else begin
            in_ack <= capture;
            if (capture) begin
                in_data <= 32'(sw_s2);
            end
        end
    end

endmodule

// File: tb/tb_io_input_controller.sv
module tb_io_input_controller;

    localparam int D  = 4;
    localparam int SW = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          confirm_n = 1'b1;
    logic [SW-1:0] switch_raw = '0;
    logic          in_req = 1'b0;
    logic          in_ack;
    logic [31:0]   in_data;
    logic          waiting;
    logic          confirm_pulse;

    int nvec = 0;
    int nerr = 0;
    int n_ack = 0;
    int n_pulse = 0;
    bit chk_en = 0;

    io_input_controller #(.DEBOUNCE_CYCLES(D), .SW_WIDTH(SW)) dut (
        .clock(clock),
        .reset(reset),
        .confirm_n(confirm_n),
        .switch_raw(switch_raw),
        .in_req(in_req),
        .in_ack(in_ack),
        .in_data(in_data),
        .waiting(waiting),
        .confirm_pulse(confirm_pulse)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the synchronizer is a two-sample delay queue, the
    // debouncer accepts a level after D consecutive disagreeing samples, and
    // the handshake is tracked with "request pending" / "awaiting release".
    bit          q_btn[$];
    logic [SW-1:0] q_sw[$];
    bit          m_acc;
    int          m_run;
    bit          m_pending, m_hold;
    bit          m_ack, m_pulse;
    logic [31:0] m_data;
    bit          lvl, acc_old, evt;
    logic [SW-1:0] sw_seen;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q_btn = {1'b0, 1'b0};
            q_sw  = {SW'(0), SW'(0)};
            m_acc = 0; m_run = 0; m_pending = 0; m_hold = 0;
            m_ack = 0; m_pulse = 0; m_data = 0;
        end else begin
            lvl     = q_btn.pop_front();
            sw_seen = q_sw.pop_front();
            q_btn.push_back(!confirm_n);
            q_sw.push_back(switch_raw);
            acc_old = m_acc;
            evt     = 0;
            if (lvl != m_acc) begin
                m_run++;
                if (m_run == D) begin
                    m_acc = lvl;
                    m_run = 0;
                    evt   = lvl;
                end
            end else begin
                m_run = 0;
            end
            m_pulse = evt;
            m_ack   = 0;
            if (m_pending) begin
                if (!in_req) m_pending = 0;
                else if (evt) begin
                    m_ack = 1; m_data = {22'd0, sw_seen}; m_pending = 0; m_hold = 1;
                end
            end else if (m_hold) begin
                if (!acc_old) m_hold = 0;
            end else if (in_req) begin
                m_pending = 1;
            end
        end
    end

    always @(posedge clock) begin
        #1;
        if (!reset && chk_en) begin
            chk("model_in_ack", {31'd0, in_ack}, {31'd0, m_ack});
            chk("model_in_data", in_data, m_data);
            chk("model_waiting", {31'd0, waiting}, {31'd0, m_pending});
            chk("model_confirm_pulse", {31'd0, confirm_pulse}, {31'd0, m_pulse});
            if (in_ack) n_ack++;
            if (confirm_pulse) n_pulse++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Called at a negedge: drive the press and count edges to the pulse.
    task automatic press_wait(output int edges);
        edges = -1;
        confirm_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock);
            #1;
            if (confirm_pulse) begin
                edges = i;
                break;
            end
        end
    endtask

    int e;
    int ack0, pulse0;

    initial begin
        // 1: reset and idle
        #2;
        chk("rst_in_ack", {31'd0, in_ack}, 32'd0);
        chk("rst_in_data", in_data, 32'd0);
        chk("rst_waiting", {31'd0, waiting}, 32'd0);
        chk("rst_pulse", {31'd0, confirm_pulse}, 32'd0);
        tick(2);
        reset = 1'b0;
        chk_en = 1;
        tick(3);
        press_wait(e);
        chk("idle_press_latency", e, D + 2);
        chk("idle_press_no_ack", n_ack, 0);
        chk("idle_press_data", in_data, 32'd0);
        @(negedge clock);
        confirm_n = 1'b1;
        tick(10);

        // 2: capture 2A5
        switch_raw = 10'h2A5;
        in_req = 1'b1;
        tick(2);
        chk("req_waiting", {31'd0, waiting}, 32'd1);
        press_wait(e);
        chk("req_latency", e, D + 2);
        chk("req_ack", {31'd0, in_ack}, 32'd1);
        chk("req_data", in_data, 32'h0000_02A5);
        chk("req_waiting_clear", {31'd0, waiting}, 32'd0);
        @(negedge clock);
        in_req = 1'b0;
        confirm_n = 1'b1;
        tick(10);

        // 3: bounce shorter than D
        in_req = 1'b1;
        tick(2);
        ack0 = n_ack; pulse0 = n_pulse;
        confirm_n = 1'b0; tick(3);
        confirm_n = 1'b1; tick(1);
        confirm_n = 1'b0; tick(3);
        confirm_n = 1'b1; tick(8);
        chk("bounce_no_pulse", n_pulse, pulse0);
        chk("bounce_no_ack", n_ack, ack0);
        chk("bounce_waiting", {31'd0, waiting}, 32'd1);
        in_req = 1'b0;
        tick(2);

        // 4: held button cannot satisfy the next request
        switch_raw = 10'h155;
        in_req = 1'b1;
        tick(2);
        press_wait(e);
        chk("held_first_data", in_data, 32'h0000_0155);
        @(negedge clock);
        in_req = 1'b0;
        tick(1);
        in_req = 1'b1;
        ack0 = n_ack;
        tick(10);
        chk("held_no_ack", n_ack, ack0);
        chk("held_waiting_low", {31'd0, waiting}, 32'd0);
        confirm_n = 1'b1;
        switch_raw = 10'h3FF;
        tick(10);
        chk("released_waiting", {31'd0, waiting}, 32'd1);
        press_wait(e);
        chk("second_ack", {31'd0, in_ack}, 32'd1);
        chk("second_data", in_data, 32'h0000_03FF);
        @(negedge clock);
        in_req = 1'b0;
        confirm_n = 1'b1;
        tick(10);

        // 5: request drops on the press edge
        switch_raw = 10'h001;
        in_req = 1'b1;
        tick(3);
        ack0 = n_ack; pulse0 = n_pulse;
        confirm_n = 1'b0;
        repeat (D + 1) @(posedge clock);
        @(negedge clock);
        in_req = 1'b0;
        @(posedge clock);
        #1;
        chk("drop_pulse", {31'd0, confirm_pulse}, 32'd1);
        chk("drop_no_ack", {31'd0, in_ack}, 32'd0);
        chk("drop_data", in_data, 32'h0000_03FF);
        @(negedge clock);
        chk("drop_waiting", {31'd0, waiting}, 32'd0);
        confirm_n = 1'b1;
        tick(10);
        chk("drop_ack_count", n_ack, ack0);

        // 6: reset mid-request
        switch_raw = 10'h0AA;
        in_req = 1'b1;
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_in_ack", {31'd0, in_ack}, 32'd0);
        chk("midrst_in_data", in_data, 32'd0);
        chk("midrst_waiting", {31'd0, waiting}, 32'd0);
        chk("midrst_pulse", {31'd0, confirm_pulse}, 32'd0);
        tick(2);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("postrst_waiting", {31'd0, waiting}, 32'd1);
        @(negedge clock);
        press_wait(e);
        chk("postrst_ack", {31'd0, in_ack}, 32'd1);
        chk("postrst_data", in_data, 32'h0000_00AA);
        @(negedge clock);
        in_req = 1'b0;
        confirm_n = 1'b1;
        tick(10);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
